// File: rtl/predistort_pkg.sv
// Shared definitions for the predistorter taps-loading scheduler: settings offsets,
// control bit positions, FSM encoding and a round-robin index helper.
package predistort_pkg;

  localparam int unsigned SR_TAP_DATA = 0;
  localparam int unsigned SR_COMMIT   = 1;
  localparam int unsigned SR_CTRL     = 2;

  localparam int unsigned CTRL_PTR_RST = 0;
  localparam int unsigned CTRL_ERR_CLR = 1;
  localparam int unsigned CTRL_ABORT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_STREAM,
    ST_DONE
  } state_t;

  function automatic int unsigned rr_offset(input int unsigned base, input int unsigned off,
                                            input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the requester after the last one granted.
// The last-grant pointer advances only when a grant is consumed.
module rr_arbiter
  import predistort_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] last_idx;
  logic [IW-1:0] grant_idx;
  logic          found;
  int unsigned   cand;

  always_comb begin
    grant     = '0;
    grant_idx = last_idx;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = rr_offset(int'(last_idx), i, N);
      if (!found && req[cand[IW-1:0]]) begin
        found                = 1'b1;
        grant[cand[IW-1:0]]  = 1'b1;
        grant_idx            = cand[IW-1:0];
      end
    end
  end

  // Reset to the highest index so channel 0 is first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx <= IW'(N - 1);
    end else if (advance && found) begin
      last_idx <= grant_idx;
    end
  end

endmodule

// File: rtl/predistort_taps_sched.sv
// Captures one tap set from the settings bus into a staging buffer and replays it as an
// AXI taps stream to each committed channel, one whole set per round-robin grant.
module predistort_taps_sched
  import predistort_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned NUM_TAPS     = 128,
  parameter int unsigned TAP_WIDTH    = 16,
  parameter int unsigned SR_BASE      = 192
) (
  input  logic                    ce_clk,
  input  logic                    ce_rst_n,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  output logic [TAP_WIDTH-1:0]    taps_tdata,
  output logic                    taps_tlast,
  output logic [NUM_CHANNELS-1:0] taps_tvalid,
  input  logic [NUM_CHANNELS-1:0] taps_tready,
  output logic                    busy,
  output logic [NUM_CHANNELS-1:0] pending,
  output logic [NUM_CHANNELS-1:0] done_stb,
  output logic [31:0]             status
);

  localparam int unsigned PTR_W = $clog2(NUM_TAPS);
  localparam logic [7:0] ADDR_TAP    = 8'(SR_BASE + SR_TAP_DATA);
  localparam logic [7:0] ADDR_COMMIT = 8'(SR_BASE + SR_COMMIT);
  localparam logic [7:0] ADDR_CTRL   = 8'(SR_BASE + SR_CTRL);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_TAPS - 1);

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [NUM_CHANNELS-1:0] pend_q, pend_nxt;
  logic [NUM_CHANNELS-1:0] grant_oh, arb_grant;
  logic                    err_wr, err_wrap;
  logic [TAP_WIDTH-1:0]    tap_mem [NUM_TAPS];

  logic hit_tap, hit_commit, hit_ctrl, abort, beat, last_tap, tap_accept;
  logic unused_set_data;

  assign hit_tap    = set_stb && (set_addr == ADDR_TAP);
  assign hit_commit = set_stb && (set_addr == ADDR_COMMIT);
  assign hit_ctrl   = set_stb && (set_addr == ADDR_CTRL);
  assign abort      = hit_ctrl && set_data[CTRL_ABORT];
  assign tap_accept = hit_tap && (state == ST_IDLE);
  assign beat       = (state == ST_STREAM) && |(taps_tready & grant_oh);
  assign last_tap   = (rd_ptr == PTR_LAST);
  assign unused_set_data = ^set_data;

  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .clk     (ce_clk),
    .rst_n   (ce_rst_n),
    .req     (pend_q),
    .advance (state == ST_ARB),
    .grant   (arb_grant)
  );

  always_ff @(posedge ce_clk) begin
    if (tap_accept) begin
      tap_mem[wr_ptr] <= set_data[TAP_WIDTH-1:0];
    end
  end

  // A commit landing on the same bit the arbiter is clearing must win.
  always_comb begin
    pend_nxt = pend_q;
    if (state == ST_ARB) pend_nxt = pend_nxt & ~arb_grant;
    if (hit_commit)      pend_nxt = pend_nxt | set_data[NUM_CHANNELS-1:0];
    if (abort)           pend_nxt = '0;
  end

  // DONE chains straight into ARB so back-to-back sets are separated by two idle cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|pend_q) state_nxt = ST_ARB;
      ST_ARB:    state_nxt = (|pend_q) ? ST_STREAM : ST_IDLE;
      ST_STREAM: begin
        if (abort)                 state_nxt = ST_IDLE;
        else if (beat && last_tap) state_nxt = ST_DONE;
      end
      ST_DONE:   state_nxt = (|pend_q) ? ST_ARB : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state    <= ST_IDLE;
      pend_q   <= '0;
      grant_oh <= '0;
      rd_ptr   <= '0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      if (state == ST_ARB) begin
        grant_oh <= arb_grant;
        rd_ptr   <= '0;
      end else if (beat) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      wr_ptr   <= '0;
      err_wr   <= 1'b0;
      err_wrap <= 1'b0;
    end else begin
      if (hit_tap) begin
        if (state != ST_IDLE) begin
          err_wr <= 1'b1;
        end else if (wr_ptr == PTR_LAST) begin
          wr_ptr   <= '0;
          err_wrap <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (hit_ctrl) begin
        if (set_data[CTRL_PTR_RST]) wr_ptr <= '0;
        if (set_data[CTRL_ERR_CLR]) begin
          err_wr   <= 1'b0;
          err_wrap <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    taps_tvalid = '0;
    taps_tdata  = '0;
    taps_tlast  = 1'b0;
    done_stb    = '0;
    if (state == ST_STREAM) begin
      taps_tvalid = grant_oh;
      taps_tdata  = tap_mem[rd_ptr];
      taps_tlast  = last_tap;
    end
    if (state == ST_DONE) done_stb = grant_oh;
  end

  always_comb begin
    status                       = '0;
    status[31]                   = err_wr;
    status[30]                   = err_wrap;
    status[16 +: NUM_CHANNELS]   = pend_q;
    status[PTR_W-1:0]            = wr_ptr;
  end

  assign busy    = (state != ST_IDLE);
  assign pending = pend_q;

endmodule
